// File: rtl/stb_axi_wr_engine_if.sv
// AXI write-only channel bundle (AW/W/B) between the store engine and the fabric.
interface stb_axi_wr_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 128
);
    localparam int BYTE_STRB = DATA_WIDTH / 8;

    logic [3:0]            awid;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic [3:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  awlock;
    logic [3:0]            awcache;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;

    logic [DATA_WIDTH-1:0] wdata;
    logic [BYTE_STRB-1:0]  wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;

    logic [3:0]            bid;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst,
        output awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst,
        input  awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/stb_axi_wr_engine.sv
// Store engine: streams UR SRAM words to external memory as AXI write bursts,
// splitting at 4KB boundaries and buffering UR data in a 2-entry FIFO.
module stb_axi_wr_engine #(
    parameter int         DATA_WIDTH    = 128,
    parameter int         ADDR_WIDTH    = 32,
    parameter int         UR_ADDR_WIDTH = 11,
    parameter int         LEN_WIDTH     = 4,
    parameter logic [3:0] AXI_ID        = 4'd0,
    localparam int        BYTE_STRB     = DATA_WIDTH / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_inst_valid,
    output logic                     o_inst_ready,
    input  logic [ADDR_WIDTH-1:0]    i_inst_addr,
    input  logic [UR_ADDR_WIDTH-1:0] i_inst_ur_addr,
    input  logic [LEN_WIDTH-1:0]     i_inst_len,
    input  logic [BYTE_STRB-1:0]     i_inst_last_strb,
    output logic                     o_done,
    output logic                     o_done_err,
    output logic                     o_ur_re,
    output logic [UR_ADDR_WIDTH-1:0] o_ur_addr,
    input  logic [DATA_WIDTH-1:0]    i_ur_rdata,
    stb_axi_wr_engine_if.master      axi,
    output logic [2:0]               o_state
);
    localparam int SZ = $clog2(BYTE_STRB);
    localparam int CW = LEN_WIDTH + 1;
    localparam int HW = ADDR_WIDTH - 12;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0]    aw_addr;
    logic [3:0]               aw_len;
    logic [CW-1:0]            rem;
    logic [CW-1:0]            w_left;
    logic [3:0]               w_cnt;
    logic [CW-1:0]            rd_left;
    logic [UR_ADDR_WIDTH-1:0] ur_ptr;
    logic [BYTE_STRB-1:0]     last_strb;
    logic                     err;
    logic                     re_d;

    logic [DATA_WIDTH-1:0]    mem [2];
    logic                     rd_ptr;
    logic                     wr_ptr;
    logic [1:0]               cnt;

    logic                  accept;
    logic [ADDR_WIDTH-1:0] addr_al;
    logic [12:0]           to_bnd;
    logic [CW-1:0]         total;
    logic [CW-1:0]         first;
    logic [1:0]            occ;
    logic                  w_fire;
    logic                  w_last;
    logic                  fin;
    logic                  b_fire;
    logic                  unused;

    assign accept  = (state == S_IDLE) && i_inst_valid;
    assign addr_al = {i_inst_addr[ADDR_WIDTH-1:SZ], {SZ{1'b0}}};
    assign to_bnd  = (13'h1000 - {1'b0, addr_al[11:0]}) >> SZ;
    assign total   = CW'(i_inst_len) + CW'(1);
    assign first   = (to_bnd < 13'(total)) ? to_bnd[CW-1:0] : total;
    assign unused  = ^{axi.bid, i_inst_addr[SZ-1:0]};

    // Prefetch only while buffered plus in-flight data leaves a free slot
    assign occ     = cnt + {1'b0, re_d};
    assign o_ur_re = (state != S_IDLE) && (rd_left != '0) && (occ < 2'd2);
    assign o_ur_addr = ur_ptr;

    assign axi.awvalid = (state == S_AW);
    assign axi.awaddr  = aw_addr;
    assign axi.awlen   = aw_len;
    assign axi.awid    = axi.awvalid ? AXI_ID : 4'd0;
    assign axi.awsize  = axi.awvalid ? 3'(SZ) : 3'd0;
    assign axi.awburst = axi.awvalid ? 2'b01 : 2'b00;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = axi.awvalid ? 4'b0011 : 4'b0000;
    assign axi.awprot  = 3'b000;

    assign w_fire     = axi.wvalid && axi.wready;
    assign w_last     = (w_cnt == aw_len);
    assign fin        = (w_left == CW'(1));
    assign axi.wvalid = (state == S_W) && (cnt != 2'd0);
    assign axi.wdata  = mem[rd_ptr];
    assign axi.wlast  = axi.wvalid && w_last;
    assign axi.wstrb  = !axi.wvalid ? '0 : (fin ? last_strb : '1);

    assign axi.bready = (state == S_B);
    assign b_fire     = axi.bvalid && axi.bready;

    assign o_inst_ready = (state == S_IDLE);
    assign o_done       = (state == S_DONE);
    assign o_done_err   = o_done && err;
    assign o_state      = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE: if (i_inst_valid) state_nx = S_AW;
            S_AW:   if (axi.awready) state_nx = S_W;
            S_W:    if (w_fire && w_last) state_nx = S_B;
            S_B:    if (axi.bvalid) state_nx = (rem != '0) ? S_AW : S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_addr   <= '0;
            aw_len    <= '0;
            rem       <= '0;
            w_left    <= '0;
            w_cnt     <= '0;
            rd_left   <= '0;
            ur_ptr    <= '0;
            last_strb <= '0;
            err       <= 1'b0;
            re_d      <= 1'b0;
        end else begin
            if (accept) begin
                aw_addr   <= addr_al;
                aw_len    <= 4'(first - CW'(1));
                rem       <= total - first;
                w_left    <= total;
                rd_left   <= total;
                ur_ptr    <= i_inst_ur_addr;
                last_strb <= i_inst_last_strb;
                err       <= 1'b0;
                w_cnt     <= '0;
            end
            // Second burst always starts on the next 4KB page
            if (b_fire) begin
                err <= err || (axi.bresp != 2'b00);
                if (rem != '0) begin
                    aw_addr <= {aw_addr[ADDR_WIDTH-1:12] + HW'(1), 12'h000};
                    aw_len  <= 4'(rem - CW'(1));
                    rem     <= '0;
                end
            end
            if (o_ur_re) begin
                rd_left <= rd_left - CW'(1);
                ur_ptr  <= ur_ptr + UR_ADDR_WIDTH'(1);
            end
            re_d <= o_ur_re;
            if (w_fire) begin
                w_left <= w_left - CW'(1);
                w_cnt  <= w_last ? 4'd0 : w_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            cnt    <= '0;
        end else begin
            if (re_d) begin
                mem[wr_ptr] <= i_ur_rdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (w_fire) rd_ptr <= ~rd_ptr;
            cnt <= cnt + 2'(re_d) - 2'(w_fire);
        end
    end
endmodule

// File: tb/tb_stb_axi_wr_engine.sv
// Randomized bench for stb_axi_wr_engine against a burst/beat-level
// reference model of the expected AXI write traffic.
module tb_stb_axi_wr_engine;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam int UW = 11;
    localparam int LW = 4;
    localparam int BS = DW / 8;
    localparam int URN = 1 << UW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          i_inst_valid;
    logic          o_inst_ready;
    logic [AW-1:0] i_inst_addr;
    logic [UW-1:0] i_inst_ur_addr;
    logic [LW-1:0] i_inst_len;
    logic [BS-1:0] i_inst_last_strb;
    logic          o_done;
    logic          o_done_err;
    logic          o_ur_re;
    logic [UW-1:0] o_ur_addr;
    logic [DW-1:0] i_ur_rdata;
    logic [2:0]    o_state;

    int total_n = 0;
    int bad_n = 0;
    logic [1:0] bq[$];
    logic [DW-1:0] ur_mem [URN];

    always #5 clk = ~clk;

    stb_axi_wr_engine_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi ();

    stb_axi_wr_engine #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .UR_ADDR_WIDTH(UW),
        .LEN_WIDTH(LW), .AXI_ID(4'd0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_inst_valid(i_inst_valid), .o_inst_ready(o_inst_ready),
        .i_inst_addr(i_inst_addr), .i_inst_ur_addr(i_inst_ur_addr),
        .i_inst_len(i_inst_len), .i_inst_last_strb(i_inst_last_strb),
        .o_done(o_done), .o_done_err(o_done_err),
        .o_ur_re(o_ur_re), .o_ur_addr(o_ur_addr), .i_ur_rdata(i_ur_rdata),
        .axi(axi), .o_state(o_state)
    );

    // UR SRAM: data valid one cycle after a read; garbage otherwise
    always @(posedge clk)
        i_ur_rdata <= o_ur_re ? ur_mem[o_ur_addr]
                              : {$urandom, $urandom, $urandom, $urandom};

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        total_n++;
        if (got !== exp) begin
            bad_n++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic run_inst(input logic [AW-1:0] addr, input logic [UW-1:0] ur,
                            input logic [LW-1:0] len, input logic [BS-1:0] strb,
                            input int md, input logic [1:0] r0,
                            input logic [1:0] r1, input bit hold);
        logic [AW-1:0] a;
        logic [AW-1:0] eaddr [2];
        int elen [2];
        int n, bnd, nb, wk, awk, bk, reads, pops, maxocc;
        bit accepted, done, pend, eerr;
        logic [AW-1:0] pend_addr;
        logic [DW-1:0] ed;

        a = addr & ~AW'(BS - 1);
        n = int'(len) + 1;
        bnd = (4096 - int'(a[11:0])) / BS;
        eaddr[0] = a;
        if (n <= bnd) begin
            nb = 1; elen[0] = n; eaddr[1] = '0; elen[1] = 0;
        end else begin
            nb = 2; elen[0] = bnd;
            eaddr[1] = (a + AW'(4096)) & ~AW'(4095);
            elen[1] = n - bnd;
        end
        eerr = (r0 != 2'b00) || (nb == 2 && r1 != 2'b00);

        wk = 0; awk = 0; bk = 0; reads = 0; pops = 0; maxocc = 0;
        done = 0; pend = 0; pend_addr = '0;
        i_inst_addr = addr; i_inst_ur_addr = ur;
        i_inst_len = len; i_inst_last_strb = strb;
        i_inst_valid = 1'b1;
        accepted = o_inst_ready;

        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (accepted) begin
                if (hold) begin
                    i_inst_valid = 1'b1;
                    i_inst_addr = $urandom;
                    i_inst_ur_addr = UW'($urandom);
                    i_inst_len = LW'($urandom);
                    i_inst_last_strb = BS'($urandom);
                    chk("busy_ready", o_inst_ready, 0);
                end else begin
                    i_inst_valid = 1'b0;
                end
            end
            if (pend) begin
                chk("aw_hold_valid", axi.awvalid, 1);
                chk("aw_hold_addr", axi.awaddr, pend_addr);
            end
            case (md)
                0: begin axi.awready = 1'b1; axi.wready = 1'b1; end
                1: begin
                    axi.awready = 1'($urandom % 2);
                    axi.wready = 1'($urandom % 2);
                end
                default: begin
                    axi.awready = 1'b1;
                    axi.wready = (cyc % 3 == 0);
                end
            endcase
            if (bq.size() > 0) begin
                axi.bvalid = (md != 1) || ($urandom % 2 == 0);
                axi.bresp = bq[0];
            end else begin
                axi.bvalid = (md == 1) && ($urandom % 4 == 0);
                axi.bresp = 2'b11;
            end
            if (axi.bvalid && axi.bready && bq.size() > 0) void'(bq.pop_front());
            pend = 0;
            if (axi.awvalid) begin
                if (axi.awready) begin
                    if (awk < nb) begin
                        chk("awaddr", axi.awaddr, eaddr[awk]);
                        chk("awlen", axi.awlen, elen[awk] - 1);
                        chk("awsize", axi.awsize, $clog2(BS));
                        chk("awburst", axi.awburst, 1);
                        chk("awcache", axi.awcache, 3);
                        chk("awid", axi.awid, 0);
                    end else begin
                        chk("aw_extra", awk + 1, nb);
                    end
                    awk++;
                end else begin
                    pend = 1;
                    pend_addr = axi.awaddr;
                end
            end
            if (o_ur_re) reads++;
            if (axi.wvalid && axi.wready) begin
                if (wk < n) begin
                    ed = ur_mem[(int'(ur) + wk) % URN];
                    chk("wdata", axi.wdata, ed);
                    chk("wstrb", axi.wstrb, (wk == n - 1) ? strb : {BS{1'b1}});
                    chk("wlast", axi.wlast,
                        (wk == elen[0] - 1) || (wk == n - 1));
                end else begin
                    chk("w_extra", wk + 1, n);
                end
                if (axi.wlast) begin
                    bq.push_back(bk == 0 ? r0 : r1);
                    bk++;
                end
                wk++;
                pops++;
            end
            if (reads - pops > maxocc) maxocc = reads - pops;
            if (o_done) begin
                chk("done_err", o_done_err, eerr);
                done = 1;
            end
            if (!accepted && o_inst_ready) accepted = 1;
        end
        if (!done) chk("timeout_done", 0, 1);
        chk("beats", wk, n);
        chk("bursts", awk, nb);
        chk("ur_reads", reads, n);
        chk("buf_le_2", maxocc <= 2, 1);
        @(negedge clk);
        chk("done_pulse", o_done, 0);
        chk("ready_back", o_inst_ready, 1);
    endtask

    initial begin
        logic [AW-1:0] ra;
        int k;
        for (int i = 0; i < URN; i++)
            ur_mem[i] = {$urandom, $urandom, $urandom, $urandom};
        i_inst_valid = 0; i_inst_addr = '0; i_inst_ur_addr = '0;
        i_inst_len = '0; i_inst_last_strb = '0;
        axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        axi.bresp = 2'b00; axi.bid = 4'd0;
        #1;
        chk("rst_ready", o_inst_ready, 1);
        chk("rst_state", o_state, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid", axi.wvalid, 0);
        chk("rst_bready", axi.bready, 0);
        chk("rst_done", o_done, 0);
        chk("rst_ur_re", o_ur_re, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_inst(32'h1000, 11'd5, 4'd0, 16'h00FF, 0, 2'b00, 2'b00, 0);
        run_inst(32'h0FC0, 11'd40, 4'd15, 16'hFFFF, 0, 2'b00, 2'b00, 0);
        run_inst(32'h3000, 11'd200, 4'd7, 16'h0F0F, 2, 2'b00, 2'b00, 0);
        run_inst(32'h1FE0, 11'd7, 4'd5, 16'h0003, 1, 2'b10, 2'b00, 0);
        run_inst(32'h5000, 11'd300, 4'd4, 16'h1234, 1, 2'b00, 2'b00, 1);
        run_inst(32'h6008, 11'd2044, 4'd9, 16'h8001, 1, 2'b00, 2'b11, 0);

        i_inst_addr = 32'h2000; i_inst_ur_addr = 11'd100;
        i_inst_len = 4'd15; i_inst_last_strb = '1; i_inst_valid = 1'b1;
        axi.awready = 1'b1; axi.wready = 1'b1; axi.bvalid = 1'b0;
        k = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            i_inst_valid = 1'b0;
            if (axi.wvalid) k++;
            if (k == 3) break;
        end
        chk("rst_reach_w", k, 3);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_awvalid", axi.awvalid, 0);
        chk("mid_rst_wvalid", axi.wvalid, 0);
        chk("mid_rst_bready", axi.bready, 0);
        chk("mid_rst_done", o_done, 0);
        chk("mid_rst_state", o_state, 0);
        chk("mid_rst_ur_re", o_ur_re, 0);
        @(negedge clk);
        rst_n = 1'b1;
        bq.delete();
        axi.awready = 0; axi.wready = 0;
        @(negedge clk);
        run_inst(32'h7FF0, 11'd9, 4'd3, 16'h00F0, 0, 2'b00, 2'b00, 0);

        for (int t = 0; t < 25; t++) begin
            ra = $urandom;
            if ($urandom % 2 == 0)
                ra = (ra & 32'hFFFF_F000) + 32'd4096
                     - AW'(BS * $urandom_range(1, 20)) + AW'($urandom_range(0, 15));
            run_inst(ra,
                     ($urandom % 3 == 0) ? UW'($urandom_range(2030, 2047)) : UW'($urandom),
                     LW'($urandom), BS'($urandom), 1,
                     ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                     ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                     ($urandom % 5 == 0));
        end
        i_inst_valid = 1'b0;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total_n, bad_n);
        $finish;
    end
endmodule
